top: RTL and testbench

- Single-channel closed-loop controller: reads a 12-bit sample from an ADC128S022-style serial ADC over a 4-wire SPI link.
- Computes a PID correction against a fixed setpoint.
- Drives the result as the duty cycle of a single PWM output.
- Top level of the PID design; pins connect directly to the ADC and to the actuator driver.

---
 rtl/top.sv | 180 ++++++++++++++++++
 tb/tb_top.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// Closed-loop controller: ADC128S022-style SPI sample capture, PID against a fixed setpoint,
// and the clamped result used as the duty cycle of a single glitch-free PWM output.
module top #(
    parameter int CLK_DIV     = 4,
    parameter int ADC_CHANNEL = 0,
    parameter int SETPOINT    = 2048,
    parameter int KP          = 4,
    parameter int KI          = 1,
    parameter int KD          = 0,
    parameter int SHIFT       = 4,
    parameter int PWM_BITS    = 12
) (
    input  logic clk,
    input  logic rst,
    output logic ADC_SCLK,
    output logic ADC_CS_N,
    input  logic ADC_DOUT,
    output logic ADC_DIN,
    output logic pwm_out
);

    localparam int              CW       = $clog2(2 * CLK_DIV) + 1;
    localparam logic [CW-1:0]   DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   GAP_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [2:0]      CHAN     = 3'(ADC_CHANNEL);
    localparam logic [11:0]     SP       = 12'(SETPOINT);
    localparam logic [5:0]      LAST_EVT = 6'd32;
    localparam logic signed [47:0] KP_S  = 48'(KP);
    localparam logic signed [47:0] KI_S  = 48'(KI);
    localparam logic signed [47:0] KD_S  = 48'(KD);
    localparam logic signed [47:0] D_MAX = 48'((1 << PWM_BITS) - 1);
    localparam logic signed [24:0] I_MAX = 25'sd8388607;
    localparam logic signed [24:0] I_MIN = -25'sd8388607;

    typedef enum logic [1:0] {IDLE, CONV, GAP} state_t;

    state_t               state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [5:0]           edge_cnt, edge_d;
    logic                 sclk_d, cs_d, din_d;
    logic [11:0]          shift, shift_d;
    logic [11:0]          sample, sample_d;
    logic                 sample_valid, valid_d;

    logic signed [23:0]   integral, int_new;
    logic signed [24:0]   int_sum;
    logic signed [12:0]   err, prev_error;
    logic signed [13:0]   diff;
    logic signed [47:0]   pid_sum, pid_u;
    logic [PWM_BITS-1:0]  duty_calc, duty_next, duty, pwm_cnt;

    // SPI sequencer: CONV walks 33 timed events -- 16 falls, 16 rises, then frame end.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state;
        cnt_d   = cnt;
        edge_d  = edge_cnt;
        sclk_d  = ADC_SCLK;
        cs_d    = ADC_CS_N;
        din_d   = ADC_DIN;
        shift_d = shift;
        sample_d = sample;
        valid_d = 1'b0;
        case (state)
            IDLE: begin
                cs_d    = 1'b0;
                cnt_d   = '0;
                edge_d  = '0;
                state_d = CONV;
            end
            CONV: begin
                if (cnt == DIV_LAST) begin
                    cnt_d  = '0;
                    edge_d = edge_cnt + 6'd1;
                    if (edge_cnt == LAST_EVT) begin
                        cs_d     = 1'b1;
                        din_d    = 1'b0;
                        sample_d = shift;
                        valid_d  = 1'b1;
                        edge_d   = '0;
                        state_d  = GAP;
                    end else if (!edge_cnt[0]) begin
                        sclk_d = 1'b0;
                        case (edge_cnt[4:1])
                            4'd2:    din_d = CHAN[2];
                            4'd3:    din_d = CHAN[1];
                            4'd4:    din_d = CHAN[0];
                            default: din_d = 1'b0;
                        endcase
                    end else begin
                        sclk_d  = 1'b1;
                        shift_d = {shift[10:0], ADC_DOUT};
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d   = '0;
                    edge_d  = '0;
                    cs_d    = 1'b0;
                    state_d = CONV;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            edge_cnt     <= '0;
            ADC_SCLK     <= 1'b1;
            ADC_CS_N     <= 1'b1;
            ADC_DIN      <= 1'b0;
            shift        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            edge_cnt     <= edge_d;
            ADC_SCLK     <= sclk_d;
            ADC_CS_N     <= cs_d;
            ADC_DIN      <= din_d;
            shift        <= shift_d;
            sample       <= sample_d;
            sample_valid <= valid_d;
        end
    end

    // PID datapath; the freshly saturated integral feeds the same update's sum.
    always_comb begin
        err     = $signed({1'b0, SP}) - $signed({1'b0, sample});
        int_sum = {integral[23], integral} + {{12{err[12]}}, err};
        if (int_sum > I_MAX)
            int_new = I_MAX[23:0];
        else if (int_sum < I_MIN)
            int_new = I_MIN[23:0];
        else
            int_new = int_sum[23:0];
        diff    = {err[12], err} - {prev_error[12], prev_error};
        pid_sum = KP_S * 48'(err) + KI_S * 48'(int_new) + KD_S * 48'(diff);
        pid_u   = pid_sum >>> SHIFT;
        if (pid_u < 48'sd0)
            duty_calc = '0;
        else if (pid_u > D_MAX)
            duty_calc = '1;
        else
            duty_calc = pid_u[PWM_BITS-1:0];
    end

    // duty only reloads at the counter wrap, so a PWM period never changes mid-way.
    always_ff @(posedge clk) begin
        if (!rst) begin
            integral   <= '0;
            prev_error <= '0;
            duty_next  <= '0;
            pwm_cnt    <= '0;
            duty       <= '0;
            pwm_out    <= 1'b0;
        end else begin
            if (sample_valid) begin
                integral   <= int_new;
                prev_error <= err;
                duty_next  <= duty_calc;
            end
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == '1)
                duty <= duty_next;
            pwm_out <= (pwm_cnt < duty);
        end
    end

endmodule

// File: tb/tb_top.sv
// Bench for top: three instances (proportional, saturating, integral-only) fed by a
// behavioural serial ADC; sample/duty expectations flow through a scoreboard queue.
module tb_top;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sclk [3];
    logic        cs_n [3];
    logic        din  [3];
    logic        pwm  [3];
    logic        dout [3] = '{1'b0, 1'b0, 1'b0};
    logic [11:0] adc_val [3];
    logic [15:0] adc_sh [3];
    logic        prev_sclk [3] = '{1'b1, 1'b1, 1'b1};
    logic        prev_cs   [3] = '{1'b1, 1'b1, 1'b1};

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [11:0] sample;
        logic [11:0] duty;
    } exp_t;

    typedef struct packed {
        logic [11:0] sample;
        logic [11:0] duty;
        logic        pwm_chk;
    } vec_t;

    exp_t sb [$];
    exp_t cur;
    vec_t vecs [7];

    top #(.ADC_CHANNEL(5), .KP(16), .KI(0), .KD(0)) dut_p (
        .clk(clk), .rst(rst), .ADC_SCLK(sclk[0]), .ADC_CS_N(cs_n[0]),
        .ADC_DOUT(dout[0]), .ADC_DIN(din[0]), .pwm_out(pwm[0]));
    top #(.KP(64), .KI(0), .KD(0)) dut_s (
        .clk(clk), .rst(rst), .ADC_SCLK(sclk[1]), .ADC_CS_N(cs_n[1]),
        .ADC_DOUT(dout[1]), .ADC_DIN(din[1]), .pwm_out(pwm[1]));
    top #(.KP(0), .KI(1), .KD(0)) dut_i (
        .clk(clk), .rst(rst), .ADC_SCLK(sclk[2]), .ADC_CS_N(cs_n[2]),
        .ADC_DOUT(dout[2]), .ADC_DIN(din[2]), .pwm_out(pwm[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ADC model: loads 4 zeros + sample at CS_N fall, shifts a bit out after each SCLK fall.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (prev_cs[k] && !cs_n[k]) begin
                adc_sh[k] = {4'b0000, adc_val[k]};
            end else if (prev_sclk[k] && !sclk[k] && !cs_n[k]) begin
                dout[k]   = adc_sh[k][15];
                adc_sh[k] = {adc_sh[k][14:0], 1'b0};
            end
            prev_cs[k]   = cs_n[k];
            prev_sclk[k] = sclk[k];
        end
    end

    // Scoreboard consumer for the proportional instance.
    always @(negedge clk) begin
        if (rst && dut_p.sample_valid && sb.size() > 0) begin
            cur = sb.pop_front();
            check("sample", 32'(dut_p.sample), 32'(cur.sample));
            check("cs_high_at_valid", 32'(cs_n[0]), 32'd1);
            @(negedge clk);
            check("valid_single_pulse", 32'(dut_p.sample_valid), 32'd0);
            check("duty_next", 32'(dut_p.duty_next), 32'(cur.duty));
        end
    end

    always @(negedge clk) begin
        if (rst && dut_s.sample_valid) begin
            @(negedge clk);
            check("sat_duty_next", 32'(dut_s.duty_next), 32'd4095);
        end
    end

    int wn = 0;
    always @(negedge clk) begin
        if (!rst) begin
            wn = 0;
        end else if (dut_i.sample_valid) begin
            wn++;
            @(negedge clk);
            check("windup_duty", 32'(dut_i.duty_next), (128 * wn > 4095) ? 32'd4095 : 32'(128 * wn));
            check("windup_integral", 32'(dut_i.integral),
                  (2048 * wn > 8388607) ? 32'd8388607 : 32'(2048 * wn));
        end
    end

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!dut_p.sample_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!dut_p.sample_valid) begin
            total++;
            bad++;
            $display("FAIL wait_valid: no sample_valid within %0d clk", n);
        end
    endtask

    task automatic count_pwm(input int k, output int cnt);
        cnt = 0;
        repeat (4096) begin
            @(negedge clk);
            if (pwm[k]) cnt++;
        end
    endtask

    int falls, n, hc, hs, hi;
    logic psclk;

    initial begin
        vecs[0] = '{12'd1948, 12'd100,  1'b1};
        vecs[1] = '{12'd4095, 12'd0,    1'b1};
        vecs[2] = '{12'd0,    12'd2048, 1'b1};
        vecs[3] = '{12'd2047, 12'd1,    1'b0};
        vecs[4] = '{12'd2048, 12'd0,    1'b0};
        vecs[5] = '{12'd2100, 12'd0,    1'b0};
        vecs[6] = '{12'd1000, 12'd1048, 1'b0};

        rst = 1'b0;
        adc_val[0] = 12'hA5C;
        adc_val[1] = 12'd0;
        adc_val[2] = 12'd0;
        sb.push_back('{sample: 12'hA5C, duty: 12'd0});
        repeat (8) @(negedge clk);
        check("rst_cs_n", 32'(cs_n[0]), 32'd1);
        check("rst_sclk", 32'(sclk[0]), 32'd1);
        check("rst_din", 32'(din[0]), 32'd0);
        check("rst_pwm", 32'(pwm[0]), 32'd0);
        check("rst_duty_next", 32'(dut_p.duty_next), 32'd0);

        rst = 1'b1;
        @(negedge clk);
        check("cs_fall_after_1clk", 32'(cs_n[0]), 32'd0);

        // First frame: count SCLK falls and check the channel address on ADC_DIN.
        falls = 0;
        n     = 0;
        psclk = sclk[0];
        while (!cs_n[0] && n < 2000) begin
            @(negedge clk);
            n++;
            if (psclk && !sclk[0]) begin
                if (falls < 16)
                    check($sformatf("din_bit%0d", falls), 32'(din[0]),
                          (falls == 2 || falls == 4) ? 32'd1 : 32'd0);
                falls++;
            end
            psclk = sclk[0];
        end
        check("sclk_falls_per_frame", 32'(falls), 32'd16);
        check("sclk_high_at_cs_rise", 32'(sclk[0]), 32'd1);
        check("din_low_at_cs_rise", 32'(din[0]), 32'd0);

        for (int i = 0; i < 7; i++) begin
            wait_valid();
            @(negedge clk);
            adc_val[0] = vecs[i].sample;
            sb.push_back('{sample: vecs[i].sample, duty: vecs[i].duty});
            wait_valid();
            if (vecs[i].pwm_chk) begin
                repeat (4100) @(negedge clk);
                count_pwm(0, hc);
                check($sformatf("pwm_high_vec%0d", i), 32'(hc), 32'(vecs[i].duty));
            end
        end

        // Saturated instances: high 4095 of every 4096 clk.
        repeat (4100) @(negedge clk);
        hs = 0;
        hi = 0;
        hc = 0;
        repeat (4096) begin
            @(negedge clk);
            if (pwm[0]) hc++;
            if (pwm[1]) hs++;
            if (pwm[2]) hi++;
        end
        check("pwm_high_last_vec", 32'(hc), 32'd1048);
        check("pwm_high_kp64", 32'(hs), 32'd4095);
        check("pwm_high_windup", 32'(hi), 32'd4095);

        // Reset in the middle of a frame aborts it cleanly.
        wait_valid();
        @(negedge clk);
        adc_val[0] = 12'd500;
        n = 0;
        while (cs_n[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrst_frame_started", 32'(cs_n[0]), 32'd0);
        repeat (40) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_cs_n", 32'(cs_n[0]), 32'd1);
        check("midrst_sclk", 32'(sclk[0]), 32'd1);
        check("midrst_din", 32'(din[0]), 32'd0);
        check("midrst_pwm", 32'(pwm[0]), 32'd0);
        check("midrst_duty_next", 32'(dut_p.duty_next), 32'd0);
        check("midrst_integral", 32'(dut_i.integral), 32'd0);
        repeat (3) @(negedge clk);
        check("midrst_no_valid", 32'(dut_p.sample_valid), 32'd0);
        rst = 1'b1;
        sb.push_back('{sample: 12'd500, duty: 12'd1548});
        @(negedge clk);
        check("midrst_cs_fall_after_1clk", 32'(cs_n[0]), 32'd0);
        wait_valid();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
